ast_edn_responder: RTL
======================

# ast_edn_responder

Entropy-delivery endpoint model that answers the top-level AST EDN request interface (`ast_edn_req_i` on `opentitan`). It replaces the constant tie-off (`edn_ack`/`edn_fips`/`edn_bus` all zero) in simulation and FPGA tops. It waits for the top's one-bit entropy request and returns 32-bit pseudo-random words from a seeded Galois LFSR. Each word is returned with a one-cycle `edn_ack` after a programmable latency.

## Interface

Parameters:
- `AckLatency`, default 4: cycles from sampled request to `edn_ack_o`. Legal range 1..255; elaboration assertion otherwise.
- `LfsrSeed`, default 32'hDEADBEEF: reset value of the LFSR. Must be non-zero; elaboration assertion.
- `Fips`, default 1'b1: value driven on `edn_fips_o` during ack.

Ports:
- `clk_i`  in  1  single clock for all state.
- `rst_i`  in  1  reset, asynchronous, active-high; all flops clear immediately on assertion.
- `enable_i`  in  1  responder enable; when low, no acks are produced.
- `edn_req_i`  in  1  entropy request from the top. Held high until ack.
- `edn_ack_o`  out  1  one-cycle acknowledge; the word is valid in this cycle.
- `edn_fips_o`  out  1  FIPS flag, qualified by ack.
- `edn_bus_o`  out  32  entropy word, qualified by ack.
- `reseed_i`  in  1  load `seed_i` into the LFSR.
- `seed_i`  in  32  reseed value; zero is replaced by `LfsrSeed`.
- `words_served_o`  out  16  count of acks issued; saturates at 16'hFFFF.
- `err_o`  out  1  sticky protocol-violation flag.

## Operation

- FSM states:
  - IDLE:
    - Enters WAIT when `enable_i & edn_req_i`.
    - Loads the latency counter with `AckLatency-1`.
  - WAIT:
    - Decrements the counter each cycle.
    - At counter==0 with `edn_req_i` high, moves to ACK.
    - `enable_i` low: returns to IDLE, no error.
    - `edn_req_i` low while enabled (request withdrawn before ack): returns to IDLE and sets `err_o`.
  - ACK (one cycle):
    - Drives `edn_ack_o=1`, `edn_bus_o` = current LFSR state, `edn_fips_o=Fips`.
    - Advances the LFSR and increments `words_served_o`.
    - Next state is IDLE. A still-high request is handled from IDLE as a new request.
- LFSR:
  - 32-bit right-shifting Galois LFSR, mask 32'h80200003.
  - Step rule: `next = (s>>1) ^ (s[0] ? mask : 0)`.
  - Advances only in ACK.
- Reseed:
  - `reseed_i` loads the LFSR in the next cycle in any state.
  - If it coincides with ACK, the ack still carries the pre-reseed word, and the reseed value replaces the advanced value.
  - `seed_i==0` loads `LfsrSeed`. The all-zero state is unreachable.
- Output qualification:
  - `edn_bus_o` is 32'h0 and `edn_fips_o` is 0 whenever `edn_ack_o` is low.
  - No stale data appears on the bus.
- `err_o` clears only on reset.
- `words_served_o` holds at 16'hFFFF once reached.

## Timing

- Reset values:
  - FSM IDLE, LFSR=`LfsrSeed`, counter=0.
  - `edn_ack_o=0`, `edn_fips_o=0`, `edn_bus_o=0`, `words_served_o=0`, `err_o=0`.
- All outputs are registered; no combinational path from any input to any output.
- Request sampled high at edge t (FSM in IDLE) → `edn_ack_o` high during cycle t+AckLatency.
  - AckLatency=1 gives ack in the cycle right after the sampling edge.
- Back-to-back: a request held high through ack is re-sampled in IDLE. The next ack arrives AckLatency+1 cycles after the previous ack, so the minimum ack spacing is 2 cycles.
- `reseed_i` at edge t → the new value is visible on the first ack at or after cycle t+1.
- Reset asserted mid-WAIT or during ACK:
  - Outputs drop in the same cycle (asynchronous).
  - Any in-flight request is discarded; no ack is issued after deassertion until a new request completes full latency.
- `enable_i` low in the ACK cycle does not suppress that ack. Enable is checked only in IDLE and WAIT.

## Test plan

- **Reset defaults, single request:** reset, enable=1, AckLatency=4, req rises at cycle 10 and is held → one ack in cycle 14 with bus=32'hDEADBEEF, fips=1; words_served=1; bus=0 in all other cycles.
- **Back-to-back:** req held high for two words → second ack 5 cycles after the first with bus=32'hEF76DF74; words_served=2.
- **Reseed:**
  - seed_i=32'h00000001, reseed pulse → next ack bus=32'h00000001, following ack bus=32'h80200003.
  - seed_i=0 → next ack bus=32'hDEADBEEF.
- **Withdrawn request:** req dropped in the second WAIT cycle → no ack, FSM back to IDLE, err_o=1 and stays 1 through later successful acks until reset.
- **Enable and reset abort:**
  - enable dropped mid-WAIT → no ack, err_o stays 0.
  - rst_i asserted mid-WAIT → outputs 0 immediately; after release, a new request acks with 32'hDEADBEEF after exactly AckLatency cycles.
- **Saturation:** 65 537 requests → words_served_o reaches 16'hFFFF and holds; the ack count observed on the bus is 65 537.

Source files
------------

// File: rtl/ast_edn_responder.sv
// EDN responder endpoint: answers a one-bit entropy request with a 32-bit word
// from a seeded Galois LFSR after a fixed latency, acked for exactly one cycle.
module ast_edn_responder #(
  parameter int unsigned AckLatency = 4,
  parameter logic [31:0] LfsrSeed   = 32'hDEADBEEF,
  parameter logic        Fips       = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        edn_req_i,
  output logic        edn_ack_o,
  output logic        edn_fips_o,
  output logic [31:0] edn_bus_o,
  input  logic        reseed_i,
  input  logic [31:0] seed_i,
  output logic [15:0] words_served_o,
  output logic        err_o
);

  localparam logic [31:0] LfsrMask = 32'h80200003;
  localparam logic [7:0]  LatLoad  = 8'(AckLatency - 1);

  if (AckLatency == 0 || AckLatency > 255) begin : g_bad_latency
    $error("ast_edn_responder: AckLatency must be within 1..255");
  end
  if (LfsrSeed == 32'h0) begin : g_bad_seed
    $error("ast_edn_responder: LfsrSeed must be non-zero");
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LfsrMask : 32'h0);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_cnt_dec;
  logic        w_err_set;
  logic [31:0] r_lfsr;
  logic [31:0] w_lfsr_nxt;
  logic [31:0] w_seed_eff;
  logic        w_ack_nxt;
  logic        r_ack;
  logic        r_fips;
  logic [31:0] r_bus;
  logic [15:0] r_words_served;
  logic        r_err;

  // The IDLE cycle that samples the request counts as the first latency
  // cycle, so WAIT lasts AckLatency-1 cycles and AckLatency=1 skips it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_set   = 1'b0;
    w_cnt_dec   = r_cnt - 8'd1;
    case (r_state)
      ST_IDLE: begin
        if (enable_i && edn_req_i) begin
          w_cnt_nxt   = LatLoad;
          w_state_nxt = (LatLoad == 8'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = w_cnt_dec;
        if (!enable_i) begin
          w_state_nxt = ST_IDLE;
        end else if (!edn_req_i) begin
          w_state_nxt = ST_IDLE;
          w_err_set   = 1'b1;
        end else if (w_cnt_dec == 8'd0) begin
          w_state_nxt = ST_ACK;
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A reseed overrides the post-ack advance; the ack word itself is latched
  // on entry to ACK, so it always carries the pre-reseed value.
  always_comb begin
    w_seed_eff = (seed_i == 32'h0) ? LfsrSeed : seed_i;
    if (reseed_i) begin
      w_lfsr_nxt = w_seed_eff;
    end else if (r_state == ST_ACK) begin
      w_lfsr_nxt = lfsr_step(r_lfsr);
    end else begin
      w_lfsr_nxt = r_lfsr;
    end
    w_ack_nxt = (w_state_nxt == ST_ACK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 8'd0;
      r_lfsr         <= LfsrSeed;
      r_ack          <= 1'b0;
      r_fips         <= 1'b0;
      r_bus          <= 32'h0;
      r_words_served <= 16'h0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_ack   <= w_ack_nxt;
      r_fips  <= w_ack_nxt ? Fips : 1'b0;
      r_bus   <= w_ack_nxt ? w_lfsr_nxt : 32'h0;
      if (r_state == ST_ACK) begin
        r_words_served <= sat_inc16(r_words_served);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign edn_ack_o      = r_ack;
  assign edn_fips_o     = r_fips;
  assign edn_bus_o      = r_bus;
  assign words_served_o = r_words_served;
  assign err_o          = r_err;

endmodule
